// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited imem requests and
// buffers in-order responses for decode. Optional counters enabled by FETCH_PERF_EN.
module fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [63:0] dec_pc,
    output logic [9:0]  dec_opcode,
    input  logic        dec_ready,
    output logic [63:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [63:0]   r_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_aq_wr;
    logic [PW-1:0] r_aq_rd;
    logic [31:0]   r_fifo_instr [FIFO_DEPTH];
    logic [63:0]   r_fifo_pc    [FIFO_DEPTH];
    logic [63:0]   r_aq_addr    [FIFO_DEPTH];

    logic [63:0]   w_reset_pc;
    logic [63:0]   w_redirect_pc;
    logic [CW:0]   w_used;
    logic          w_accept;
    logic          w_rsp_tracked;
    logic          w_push;
    logic          w_pop;
    logic          w_full;

    assign w_reset_pc    = RESET_PC & ~64'h3;
    assign w_redirect_pc = redirect_pc & ~64'h3;

    // Buffered entries plus outstanding requests may never exceed the buffer size,
    // which is what guarantees every response has a FIFO slot.
    assign w_used         = {1'b0, r_count} + {1'b0, r_inflight};
    assign imem_req_valid = !reset && !redirect_valid && (w_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign pc             = r_pc;

    assign w_accept      = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding belong to requests issued before reset.
    assign w_rsp_tracked = imem_rsp_valid && (r_inflight != '0);
    assign w_push        = w_rsp_tracked && !redirect_valid && (r_drop_cnt == '0);
    assign w_full        = (r_count == CW'(FIFO_DEPTH));

    assign dec_valid  = (r_count != '0);
    assign w_pop      = dec_valid && dec_ready;
    assign dec_instr  = dec_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign dec_pc     = dec_valid ? r_fifo_pc[r_rd_ptr] : '0;
    assign dec_opcode = dec_instr[31:22];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= w_reset_pc;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_aq_wr    <= '0;
            r_aq_rd    <= '0;
        end else begin
            // The address queue tracks every outstanding request, dropped or not.
            if (w_accept) begin
                r_aq_addr[r_aq_wr] <= r_pc;
                r_aq_wr            <= r_aq_wr + PW'(1);
            end
            if (w_rsp_tracked) begin
                r_aq_rd <= r_aq_rd + PW'(1);
            end

            case ({w_accept, w_rsp_tracked})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase

            if (redirect_valid) begin
                r_pc       <= w_redirect_pc;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_drop_cnt <= w_rsp_tracked ? r_inflight - CW'(1) : r_inflight;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 64'd4;
                end
                if (w_rsp_tracked && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
                    r_fifo_pc[r_wr_ptr]    <= r_aq_addr[r_aq_rd];
                    r_wr_ptr               <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(w_push && !w_pop && w_full));

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_bubbles;
    logic        w_drop;

    assign w_drop       = w_rsp_tracked && (redirect_valid || (r_drop_cnt != '0));
    assign perf_dropped = r_perf_dropped;
    assign perf_bubbles = r_perf_bubbles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_dropped <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_drop && (r_perf_dropped != '1)) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
            if (dec_ready && !dec_valid && (r_perf_bubbles != '1)) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule
